// File: rtl/hls_deadlock_report_collector.sv
// Deadlock report collector: confirms persistent monitor block flags, latches a
// {mask, lowest index, timestamp} record and streams it as three valid/ready words.
module hls_deadlock_report_collector #(
    parameter int NUM_MON   = 4,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 32,
    parameter int IDX_W     = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_MON-1:0] block_in,
    input  logic               clear,
    output logic               report_valid,
    input  logic               report_ready,
    output logic [CNT_W-1:0]   report_data,
    output logic               report_last,
    output logic               deadlock
);
    localparam int PCNT_W = $clog2(THRESHOLD + 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND0,
        SEND1,
        SEND2,
        HOLD
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_cycle_cnt;
    logic [PCNT_W-1:0]  r_pcnt [NUM_MON];
    logic [NUM_MON-1:0] r_mask;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_ts;
    logic               r_deadlock;

    logic [NUM_MON-1:0] w_confirmed;
    logic [IDX_W-1:0]   w_low_idx;
    logic               w_any_confirmed;
    logic               w_handshake;
    logic               w_clear_hold;

    always_comb begin
        w_confirmed = '0;
        w_low_idx   = '0;
        for (int i = 0; i < NUM_MON; i++) begin
            w_confirmed[i] = (r_pcnt[i] == PCNT_W'(THRESHOLD));
        end
        // Scan downward so the lowest confirmed index is the last one written.
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (w_confirmed[i]) begin
                w_low_idx = IDX_W'(i);
            end
        end
    end

    assign w_any_confirmed = |w_confirmed;
    assign w_handshake     = report_valid & report_ready;
    assign w_clear_hold    = (r_state == HOLD) & clear;
    assign deadlock        = r_deadlock;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_confirmed) w_next_state = SEND0;
            SEND0:   if (w_handshake)     w_next_state = SEND1;
            SEND1:   if (w_handshake)     w_next_state = SEND2;
            SEND2:   if (w_handshake)     w_next_state = HOLD;
            HOLD:    if (clear)           w_next_state = IDLE;
            default:                      w_next_state = IDLE;
        endcase
    end

    always_comb begin
        report_valid = 1'b0;
        report_data  = '0;
        report_last  = 1'b0;
        case (r_state)
            SEND0: begin
                report_valid = 1'b1;
                report_data  = CNT_W'(r_mask);
            end
            SEND1: begin
                report_valid = 1'b1;
                report_data  = CNT_W'(r_idx);
            end
            SEND2: begin
                report_valid = 1'b1;
                report_data  = r_ts;
                report_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Counters and the latched record; capture only happens on leaving IDLE.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cycle_cnt <= '0;
            r_mask      <= '0;
            r_idx       <= '0;
            r_ts        <= '0;
            r_deadlock  <= 1'b0;
            for (int i = 0; i < NUM_MON; i++) begin
                r_pcnt[i] <= '0;
            end
        end else begin
            r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            for (int i = 0; i < NUM_MON; i++) begin
                if (w_clear_hold || !block_in[i]) begin
                    r_pcnt[i] <= '0;
                end else if (r_pcnt[i] != PCNT_W'(THRESHOLD)) begin
                    r_pcnt[i] <= r_pcnt[i] + PCNT_W'(1);
                end
            end
            if (r_state == IDLE && w_any_confirmed) begin
                r_mask     <= w_confirmed;
                r_idx      <= w_low_idx;
                r_ts       <= r_cycle_cnt;
                r_deadlock <= 1'b1;
            end else if (w_clear_hold) begin
                r_deadlock <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_hls_deadlock_report_collector.sv
// Bench for hls_deadlock_report_collector: directed scenarios then random traffic,
// every cycle compared against a run-length / word-queue reference model.
module tb_hls_deadlock_report_collector;
    localparam int NUM_MON   = 4;
    localparam int THRESHOLD = 4;
    localparam int CNT_W     = 32;
    localparam int IDX_W     = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic [NUM_MON-1:0] block_in;
    logic               clear;
    logic               report_valid;
    logic               report_ready;
    logic [CNT_W-1:0]   report_data;
    logic               report_last;
    logic               deadlock;

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;

    // Reference model: consecutive-high run lengths, a queue of report words
    // still owed to the host, and the sticky flag.
    int               m_run [NUM_MON];
    logic [CNT_W-1:0] m_cnt;
    bit               m_dl;
    logic [CNT_W-1:0] m_q [$];

    hls_deadlock_report_collector #(
        .NUM_MON  (NUM_MON),
        .THRESHOLD(THRESHOLD),
        .CNT_W    (CNT_W),
        .IDX_W    (IDX_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .block_in    (block_in),
        .clear       (clear),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_data (report_data),
        .report_last (report_last),
        .deadlock    (deadlock)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, tb_cyc, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [NUM_MON-1:0] mask;
        int                 low;
        bit                 pop;
        bit                 clr;
        if (reset) begin
            foreach (m_run[i]) m_run[i] = 0;
            m_cnt = '0;
            m_dl  = 1'b0;
            m_q.delete();
            return;
        end
        pop = (m_q.size() > 0) && report_ready;
        clr = clear && m_dl && (m_q.size() == 0);
        if (!m_dl) begin
            mask = '0;
            low  = -1;
            for (int i = 0; i < NUM_MON; i++) begin
                if (m_run[i] >= THRESHOLD) begin
                    mask[i] = 1'b1;
                    if (low < 0) low = i;
                end
            end
            if (mask != 0) begin
                m_q.push_back(CNT_W'(mask));
                m_q.push_back(CNT_W'(low));
                m_q.push_back(m_cnt);
                m_dl = 1'b1;
            end
        end else if (pop) begin
            void'(m_q.pop_front());
        end else if (clr) begin
            m_dl = 1'b0;
        end
        for (int i = 0; i < NUM_MON; i++) begin
            m_run[i] = (clr || !block_in[i]) ? 0 : m_run[i] + 1;
        end
        m_cnt = m_cnt + 1;
    endtask

    task automatic compare();
        check("valid", report_valid, m_q.size() > 0);
        check("last", report_last, m_q.size() == 1);
        check("deadlock", deadlock, m_dl);
        if (m_q.size() > 0) check("data", report_data, m_q[0]);
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        tb_cyc++;
        compare();
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!report_valid && n < 50) begin
            tick();
            n++;
        end
        check("wait_valid_timeout", report_valid, 1'b1);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        block_in     = '0;
        clear        = 1'b0;
        report_ready = 1'b1;
        tick();
        tick();
        check("reset_valid", report_valid, 1'b0);
        check("reset_deadlock", deadlock, 1'b0);
        reset  = 1'b0;
        tb_cyc = 0;

        // Basic detection: block_in[2] held from cycle 10.
        repeat (10) tick();
        block_in = 4'b0100;
        repeat (4) tick();
        check("c14_deadlock", deadlock, 1'b0);
        check("c14_valid", report_valid, 1'b0);
        tick();
        check("c15_valid", report_valid, 1'b1);
        check("c15_deadlock", deadlock, 1'b1);
        check("c15_mask", report_data, 32'h4);
        clear = 1'b1;                           // ignored outside HOLD
        tick();
        clear = 1'b0;
        check("c16_idx", report_data, 32'h2);
        check("c16_last", report_last, 1'b0);
        tick();
        check("c17_ts", report_data, 32'hE);
        check("c17_last", report_last, 1'b1);
        tick();
        check("c18_valid", report_valid, 1'b0);
        check("c18_deadlock", deadlock, 1'b1);
        repeat (3) tick();
        pulse_clear();
        check("clear_deadlock", deadlock, 1'b0);
        wait_valid();
        check("rereport_mask", report_data, 32'h4);
        repeat (3) tick();
        block_in = '0;
        pulse_clear();

        // Glitch: 3 high, 1 low, 3 high never confirms.
        repeat (2) tick();
        block_in = 4'b0001;
        repeat (3) tick();
        block_in = 4'b0000;
        tick();
        block_in = 4'b0001;
        repeat (3) tick();
        block_in = 4'b0000;
        repeat (3) tick();
        check("glitch_deadlock", deadlock, 1'b0);

        // Simultaneous confirmation of monitors 1 and 3.
        block_in = 4'b1010;
        wait_valid();
        check("simul_mask", report_data, 32'hA);
        tick();
        check("simul_idx", report_data, 32'h1);
        repeat (2) tick();
        block_in = '0;
        pulse_clear();

        // Backpressure in SEND1.
        block_in = 4'b0100;
        wait_valid();
        tick();
        report_ready = 1'b0;
        repeat (5) begin
            tick();
            check("bp_valid", report_valid, 1'b1);
            check("bp_idx", report_data, 32'h2);
            check("bp_last", report_last, 1'b0);
        end
        report_ready = 1'b1;
        tick();
        check("bp_advance_last", report_last, 1'b1);
        tick();
        block_in = '0;
        pulse_clear();

        // Reset while in SEND1 abandons the report and restarts the counter.
        block_in = 4'b0001;
        wait_valid();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_valid", report_valid, 1'b0);
        check("rst_deadlock", deadlock, 1'b0);
        wait_valid();
        tick();
        tick();
        check("rst_new_ts", report_data, 32'h4);
        tick();
        block_in = '0;
        pulse_clear();

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NUM_MON; i++) block_in[i] = ($urandom_range(99) < 80);
            report_ready = ($urandom_range(99) < 70);
            clear        = ($urandom_range(99) < 10);
            reset        = ($urandom_range(999) < 5);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
